// File: rtl/sprite_pkg.sv
// Shared constants and table-entry type for the sprite address generator.
// Optional feature macro: SPRITE_SCALE2X_EN (adds a per-entry 2x scale bit).
`timescale 1ns/1ps

package sprite_pkg;

    localparam int unsigned DEF_N_SPRITES  = 4;
    localparam int unsigned DEF_SPR_W_LOG2 = 6;
    localparam int unsigned DEF_SPR_H_LOG2 = 6;
    localparam int unsigned DEF_COORD_W    = 10;

    // Table entries store positions at the package coordinate width.
    localparam int unsigned ENTRY_COORD_W  = DEF_COORD_W;

    typedef struct packed {
        logic [ENTRY_COORD_W-1:0] posx;
        logic [ENTRY_COORD_W-1:0] posy;
        logic                     en;
`ifdef SPRITE_SCALE2X_EN
        logic                     scale;
`endif
    } sprite_entry_t;

    // Index width for a sprite count; a single sprite still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Per-sprite offset and range test for one raster pixel (combinational).
// Optional feature macro: SPRITE_SCALE2X_EN (doubles the range, halves the texel offset).
`timescale 1ns/1ps

module sprite_hit_calc
    import sprite_pkg::*;
#(
    parameter int unsigned COORD_W    = DEF_COORD_W,
    parameter int unsigned SPR_W_LOG2 = DEF_SPR_W_LOG2,
    parameter int unsigned SPR_H_LOG2 = DEF_SPR_H_LOG2
) (
    input  logic [COORD_W-1:0]    i_pixelx,
    input  logic [COORD_W-1:0]    i_pixely,
    input  logic [COORD_W-1:0]    i_posx,
    input  logic [COORD_W-1:0]    i_posy,
    input  logic                  i_en,
`ifdef SPRITE_SCALE2X_EN
    input  logic                  i_scale,
`endif
    output logic                  o_in_range_c,
    output logic [SPR_W_LOG2-1:0] o_idx_c,
    output logic [SPR_H_LOG2-1:0] o_idy_c
);

    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;

    // Modular subtraction: pixels left of / above the sprite wrap to large offsets.
    assign w_dx = i_pixelx - i_posx;
    assign w_dy = i_pixely - i_posy;

    always_comb begin
        o_in_range_c = 1'b0;
        o_idx_c      = '0;
        o_idy_c      = '0;
`ifdef SPRITE_SCALE2X_EN
        if (i_scale) begin
            o_in_range_c = i_en
                         && ((w_dx >> (SPR_W_LOG2 + 1)) == '0)
                         && ((w_dy >> (SPR_H_LOG2 + 1)) == '0);
            o_idx_c      = w_dx[SPR_W_LOG2:1];
            o_idy_c      = w_dy[SPR_H_LOG2:1];
        end else
`endif
        begin
            o_in_range_c = i_en
                         && ((w_dx >> SPR_W_LOG2) == '0)
                         && ((w_dy >> SPR_H_LOG2) == '0);
            o_idx_c      = w_dx[SPR_W_LOG2-1:0];
            o_idy_c      = w_dy[SPR_H_LOG2-1:0];
        end
    end

endmodule

// File: rtl/sprite_addr_gen.sv
// Two-stage sprite hit / texel address pipeline with double-buffered position table.
// Optional feature macro: SPRITE_SCALE2X_EN (per-sprite 2x scale via pos_scale).
`timescale 1ns/1ps

module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int unsigned N_SPRITES  = DEF_N_SPRITES,
    parameter int unsigned SPR_W_LOG2 = DEF_SPR_W_LOG2,
    parameter int unsigned SPR_H_LOG2 = DEF_SPR_H_LOG2,
    parameter int unsigned COORD_W    = DEF_COORD_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                pixel_valid,
    input  logic [COORD_W-1:0]                  pixelx,
    input  logic [COORD_W-1:0]                  pixely,
    input  logic                                frame_start,
    input  logic                                pos_wr,
    input  logic [idx_width(N_SPRITES)-1:0]     pos_idx,
    input  logic [COORD_W-1:0]                  pos_x,
    input  logic [COORD_W-1:0]                  pos_y,
    input  logic                                pos_en,
`ifdef SPRITE_SCALE2X_EN
    input  logic                                pos_scale,
`endif
    output logic                                out_valid,
    output logic                                hit,
    output logic [idx_width(N_SPRITES)-1:0]     sprite_id,
    output logic [SPR_H_LOG2+SPR_W_LOG2-1:0]    address
);

    localparam int unsigned IDX_W  = idx_width(N_SPRITES);
    localparam int unsigned ADDR_W = SPR_H_LOG2 + SPR_W_LOG2;

    sprite_entry_t r_shadow     [N_SPRITES];
    sprite_entry_t r_active     [N_SPRITES];
    sprite_entry_t w_shadow_nxt [N_SPRITES];

    logic [N_SPRITES-1:0]  w_in_range_c;
    logic [SPR_W_LOG2-1:0] w_idx_c [N_SPRITES];
    logic [SPR_H_LOG2-1:0] w_idy_c [N_SPRITES];

    logic                  r_s1_valid;
    logic [N_SPRITES-1:0]  r_s1_hit;
    logic [SPR_W_LOG2-1:0] r_s1_idx [N_SPRITES];
    logic [SPR_H_LOG2-1:0] r_s1_idy [N_SPRITES];

    logic                  w_win_hit;
    logic [IDX_W-1:0]      w_win_id;
    logic [ADDR_W-1:0]     w_win_addr;

    logic                  r_out_valid;
    logic                  r_hit;
    logic [IDX_W-1:0]      r_sprite_id;
    logic [ADDR_W-1:0]     r_address;

    // Next shadow contents; the commit below copies this so a coincident write is included.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (pos_wr && (32'(pos_idx) < N_SPRITES)) begin
            w_shadow_nxt[pos_idx].posx  = ENTRY_COORD_W'(pos_x);
            w_shadow_nxt[pos_idx].posy  = ENTRY_COORD_W'(pos_y);
            w_shadow_nxt[pos_idx].en    = pos_en;
`ifdef SPRITE_SCALE2X_EN
            w_shadow_nxt[pos_idx].scale = pos_scale;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_shadow <= w_shadow_nxt;
            if (frame_start) begin
                r_active <= w_shadow_nxt;
            end
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
        sprite_hit_calc #(
            .COORD_W    (COORD_W),
            .SPR_W_LOG2 (SPR_W_LOG2),
            .SPR_H_LOG2 (SPR_H_LOG2)
        ) u_hit_calc (
            .i_pixelx     (pixelx),
            .i_pixely     (pixely),
            .i_posx       (COORD_W'(r_active[g].posx)),
            .i_posy       (COORD_W'(r_active[g].posy)),
            .i_en         (r_active[g].en),
`ifdef SPRITE_SCALE2X_EN
            .i_scale      (r_active[g].scale),
`endif
            .o_in_range_c (w_in_range_c[g]),
            .o_idx_c      (w_idx_c[g]),
            .o_idy_c      (w_idy_c[g])
        );
    end

    // Stage 1: per-sprite range flags and truncated texel offsets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                r_s1_idx[i] <= '0;
                r_s1_idy[i] <= '0;
            end
        end else begin
            r_s1_valid <= pixel_valid;
            r_s1_hit   <= w_in_range_c;
            r_s1_idx   <= w_idx_c;
            r_s1_idy   <= w_idy_c;
        end
    end

    // Lowest index wins: scan from the top so the last match written is the lowest.
    always_comb begin
        w_win_hit  = 1'b0;
        w_win_id   = '0;
        w_win_addr = '0;
        if (r_s1_valid) begin
            for (int i = N_SPRITES - 1; i >= 0; i--) begin
                if (r_s1_hit[i]) begin
                    w_win_hit  = 1'b1;
                    w_win_id   = IDX_W'(i);
                    w_win_addr = {r_s1_idy[i], r_s1_idx[i]};
                end
            end
        end
    end

    // Stage 2: registered priority result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_sprite_id <= '0;
            r_address   <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_hit       <= w_win_hit;
            r_sprite_id <= w_win_id;
            r_address   <= w_win_addr;
        end
    end

    assign out_valid = r_out_valid;
    assign hit       = r_hit;
    assign sprite_id = r_sprite_id;
    assign address   = r_address;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed bench for sprite_addr_gen; exercises SPRITE_SCALE2X_EN cases when that macro is defined.
`timescale 1ns/1ps

module tb_sprite_addr_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pixel_valid;
    logic [9:0] pixelx;
    logic [9:0] pixely;
    logic       frame_start;
    logic       pos_wr;
    logic [1:0] pos_idx;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       pos_en;
`ifdef SPRITE_SCALE2X_EN
    logic       pos_scale;
`endif
    logic       out_valid;
    logic       hit;
    logic [1:0] sprite_id;
    logic [11:0] address;

    int n_checks = 0;
    int n_errors = 0;

    sprite_addr_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_valid (pixel_valid),
        .pixelx      (pixelx),
        .pixely      (pixely),
        .frame_start (frame_start),
        .pos_wr      (pos_wr),
        .pos_idx     (pos_idx),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_en      (pos_en),
`ifdef SPRITE_SCALE2X_EN
        .pos_scale   (pos_scale),
`endif
        .out_valid   (out_valid),
        .hit         (hit),
        .sprite_id   (sprite_id),
        .address     (address)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pos(input int idx, input int x, input int y, input bit en, input bit scale);
        pos_wr  = 1'b1;
        pos_idx = 2'(idx);
        pos_x   = 10'(x);
        pos_y   = 10'(y);
        pos_en  = en;
`ifdef SPRITE_SCALE2X_EN
        pos_scale = scale;
`else
        if (scale) $display("note: scale ignored without SPRITE_SCALE2X_EN");
`endif
        tick();
        pos_wr = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Single isolated pixel: out_valid must stay low after one edge and carry the result after two.
    task automatic px(input string tag, input int x, input int y,
                      input bit exp_hit, input int exp_id, input int exp_addr);
        pixel_valid = 1'b1;
        pixelx      = 10'(x);
        pixely      = 10'(y);
        tick();
        pixel_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_vld"},  32'(out_valid), 32'd1);
        check({tag, "_hit"},  32'(hit),       32'(exp_hit));
        check({tag, "_id"},   32'(sprite_id), 32'(exp_id));
        check({tag, "_addr"}, 32'(address),   32'(exp_addr));
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        pixelx      = '0;
        pixely      = '0;
        frame_start = 1'b0;
        pos_wr      = 1'b0;
        pos_idx     = '0;
        pos_x       = '0;
        pos_y       = '0;
        pos_en      = 1'b0;
`ifdef SPRITE_SCALE2X_EN
        pos_scale   = 1'b0;
`endif
        #12;
        check("rst_vld",  32'(out_valid), 32'd0);
        check("rst_hit",  32'(hit),       32'd0);
        check("rst_id",   32'(sprite_id), 32'd0);
        check("rst_addr", 32'(address),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        px("empty", 100, 50, 0, 0, 0);

        put_pos(0, 100, 50, 1, 0);
        commit();
        px("s0_org",    100,  50, 1, 0, 'h000);
        px("s0_corner", 163, 113, 1, 0, 'hFFF);
        px("s0_right",  164, 113, 0, 0, 0);
        px("s0_left",    99,  50, 0, 0, 0);

        // Sprite1 at (190,180) -> offset (10,20); sprite3 at (200,200) -> offset 0.
        put_pos(1, 190, 180, 1, 0);
        put_pos(3, 200, 200, 1, 0);
        commit();
        px("prio_1", 200, 200, 1, 1, (20 << 6) | 10);
        put_pos(1, 190, 180, 0, 0);
        commit();
        px("prio_3", 200, 200, 1, 3, 0);

        put_pos(0, 300, 300, 1, 0);
        px("shadow_old", 100,  50, 1, 0, 0);
        px("shadow_new", 300, 300, 0, 0, 0);
        commit();
        px("commit_new", 300, 300, 1, 0, 0);
        px("commit_old", 100,  50, 0, 0, 0);

        // Write coinciding with frame_start is part of the same commit.
        pos_wr = 1'b1; pos_idx = 2'd2; pos_x = 10'd500; pos_y = 10'd400; pos_en = 1'b1;
        frame_start = 1'b1;
        tick();
        pos_wr = 1'b0; frame_start = 1'b0;
        px("coinc", 501, 402, 1, 2, (2 << 6) | 1);

        // Reset with a valid result on the outputs.
        pixel_valid = 1'b1; pixelx = 10'd200; pixely = 10'd200;
        tick();
        pixel_valid = 1'b0;
        tick();
        check("pre_rst_vld", 32'(out_valid), 32'd1);
        check("pre_rst_hit", 32'(hit),       32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_vld", 32'(out_valid), 32'd0);
        check("async_hit", 32'(hit),       32'd0);
        tick();
        rst_n = 1'b1;
        px("post_rst_s3", 200, 200, 0, 0, 0);
        px("post_rst_s0", 300, 300, 0, 0, 0);
        px("post_rst_s2", 500, 400, 0, 0, 0);

        // Back-to-back stream with a commit landing between pixels.
        put_pos(0, 10, 10, 1, 0);
        commit();
        put_pos(0, 10, 10, 0, 0);
        pixel_valid = 1'b1; pixelx = 10'd10; pixely = 10'd10;
        tick();
        pixelx = 10'd73; pixely = 10'd73; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pixelx = 10'd10; pixely = 10'd10;
        check("strm0_vld",  32'(out_valid), 32'd1);
        check("strm0_hit",  32'(hit),       32'd1);
        check("strm0_addr", 32'(address),   32'd0);
        tick();
        pixel_valid = 1'b0;
        check("strm1_vld",  32'(out_valid), 32'd1);
        check("strm1_hit",  32'(hit),       32'd1);
        check("strm1_addr", 32'(address),   32'hFFF);
        tick();
        check("strm2_vld",  32'(out_valid), 32'd1);
        check("strm2_hit",  32'(hit),       32'd0);
        check("strm2_addr", 32'(address),   32'd0);
        tick();
        check("strm_idle",  32'(out_valid), 32'd0);

`ifdef SPRITE_SCALE2X_EN
        put_pos(0, 0, 0, 1, 1);
        commit();
        px("scale_in",  127, 127, 1, 0, 'hFFF);
        px("scale_out", 128,   0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
